// File: rtl/conv_drain_ctrl_pkg.sv
// Shared definitions for the subblock drain controller: block sizes,
// FSM state encoding and output stream-select codes.
package conv_drain_ctrl_pkg;

    localparam int SMALL_BYTES_DEFAULT = 132;
    localparam int LARGE_BYTES_DEFAULT = 768;

    // Wide enough for the largest block without wrapping.
    localparam int CNT_WIDTH = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        EMIT0   = 3'd3,
        EMIT1   = 3'd4,
        EMIT2   = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [1:0] SEL_STREAM0 = 2'd0;
    localparam logic [1:0] SEL_STREAM1 = 2'd1;
    localparam logic [1:0] SEL_STREAM2 = 2'd2;

endpackage

// File: rtl/conv_drain_ctrl.sv
// Drains the three subblock FIFOs of a finished code block and serializes
// them as a byte stream (stream 0, 1, 2 per FIFO word) with a valid/ready
// handshake. One request can be queued while a block is draining; a request
// arriving while that slot is full raises a sticky overrun flag.
module conv_drain_ctrl
    import conv_drain_ctrl_pkg::*;
#(
    parameter int SMALL_BYTES = SMALL_BYTES_DEFAULT,
    parameter int LARGE_BYTES = LARGE_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       computation_done,
    input  logic       length_in,
    input  logic [7:0] q0,
    input  logic [7:0] q1,
    input  logic [7:0] q2,
    input  logic       empty,
    output logic       rdreq_subblock,
    output logic [7:0] out_data,
    output logic [1:0] out_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       block_done,
    output logic       overrun
);

    localparam logic [CNT_WIDTH-1:0] SMALL_N = CNT_WIDTH'(SMALL_BYTES);
    localparam logic [CNT_WIDTH-1:0] LARGE_N = CNT_WIDTH'(LARGE_BYTES);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   byte_cnt;
    logic [CNT_WIDTH-1:0]   n_bytes;
    logic                   pend;
    logic                   pend_len;
    logic [7:0]             hold0;
    logic [7:0]             hold1;
    logic [7:0]             hold2;
    logic                   start_block;
    logic                   start_len;
    logic                   last_byte;

    // A queued request takes priority over a fresh pulse when leaving IDLE.
    assign start_block = (state == IDLE) && (computation_done || pend);
    assign start_len   = pend ? pend_len : length_in;
    assign last_byte   = (byte_cnt == (n_bytes - CNT_WIDTH'(1)));

    assign busy       = (state != IDLE);
    assign block_done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the block length on entry and count FIFO words as EMIT2 completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            n_bytes  <= '0;
        end else if (start_block) begin
            byte_cnt <= '0;
            n_bytes  <= start_len ? LARGE_N : SMALL_N;
        end else if ((state == EMIT2) && out_ready && !last_byte) begin
            byte_cnt <= byte_cnt + CNT_WIDTH'(1);
        end
    end

    // Capture the FIFO word the cycle after it was popped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold0 <= '0;
            hold1 <= '0;
            hold2 <= '0;
        end else if (state == CAPTURE) begin
            hold0 <= q0;
            hold1 <= q1;
            hold2 <= q2;
        end
    end

    // One-deep request queue and sticky overrun detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= 1'b0;
            pend_len <= 1'b0;
            overrun  <= 1'b0;
        end else if (start_block) begin
            if (pend) begin
                pend <= computation_done;
                if (computation_done) begin
                    pend_len <= length_in;
                end
            end
        end else if (computation_done && (state != IDLE)) begin
            if (!pend) begin
                pend     <= 1'b1;
                pend_len <= length_in;
            end else begin
                overrun  <= 1'b1;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next     = state;
        rdreq_subblock = 1'b0;
        out_valid      = 1'b0;
        out_sel        = SEL_STREAM0;
        out_data       = '0;
        out_last       = 1'b0;
        case (state)
            IDLE: begin
                if (start_block) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (!empty) begin
                    rdreq_subblock = 1'b1;
                    state_next     = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = EMIT0;
            end
            EMIT0: begin
                out_valid = 1'b1;
                out_sel   = SEL_STREAM0;
                out_data  = hold0;
                if (out_ready) begin
                    state_next = EMIT1;
                end
            end
            EMIT1: begin
                out_valid = 1'b1;
                out_sel   = SEL_STREAM1;
                out_data  = hold1;
                if (out_ready) begin
                    state_next = EMIT2;
                end
            end
            EMIT2: begin
                out_valid = 1'b1;
                out_sel   = SEL_STREAM2;
                out_data  = hold2;
                out_last  = last_byte;
                if (out_ready) begin
                    state_next = last_byte ? DONE : READ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/conv_drain_ctrl.md
CONV_DRAIN_CTRL -- requirements
Module: conv_drain_ctrl

Interface
REQ-001 Parameter SMALL_BYTES, default 132: bytes per subblock stream for a small code block (length_in=0).
REQ-002 Parameter LARGE_BYTES, default 768: bytes per subblock stream for a large code block (length_in=1).
REQ-003 Ports: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Ports: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports: computation_done  in  1  one-cycle pulse from the encoder: a block is complete in the subblock FIFOs.
REQ-006 Ports: length_in  in  1  block-size select from the encoder; sampled with computation_done (1 = large).
REQ-007 Ports: q0, q1, q2  in  8 each  subblock FIFO read data; valid the cycle after rdreq_subblock.
REQ-008 Ports: empty  in  1  high when the subblock FIFOs hold no data.
REQ-009 Ports: rdreq_subblock  out  1  single-cycle pop of all three subblock FIFOs.
REQ-010 Ports: out_data  out  8  serialized output byte.
REQ-011 Ports: out_sel  out  2  source stream of out_data (0, 1 or 2).
REQ-012 Ports: out_valid  out  1  out_data is valid.
REQ-013 Ports: out_ready  in  1  downstream accepts out_data when out_valid and out_ready are both high.
REQ-014 Ports: out_last  out  1  marks the final byte of a block (stream 2, last index).
REQ-015 Ports: busy  out  1  high in any state other than IDLE.
REQ-016 Ports: block_done  out  1  one-cycle pulse after the last byte of a block is accepted.
REQ-017 Ports: overrun  out  1  sticky error flag, cleared only by reset.

Function
REQ-018 FSM states: IDLE, READ, CAPTURE, EMIT0, EMIT1, EMIT2, DONE.
REQ-019 IDLE: on computation_done, or when pend is set, latch N (SMALL_BYTES or LARGE_BYTES), clear byte_cnt and go to READ.
REQ-020 READ: when empty=0, assert rdreq_subblock for exactly one cycle and go to CAPTURE; when empty=1, stay in READ with rdreq_subblock=0.
REQ-021 CAPTURE: register q0, q1, q2 into hold0..hold2, then go to EMIT0.
REQ-022 EMITk (k=0..2): drive out_valid=1, out_sel=k, out_data=holdk; hold all three outputs stable until the handshake; advance on the handshake.
REQ-023 After the EMIT2 handshake: if byte_cnt==N-1, go to DONE; otherwise increment byte_cnt and go to READ.
REQ-024 out_last=1 only in EMIT2 with byte_cnt==N-1.
REQ-025 DONE: pulse block_done for one cycle, then go to IDLE.
REQ-026 Throughput: at most 3 bytes per 5 cycles with out_ready held high; first out_valid appears 3 cycles after the computation_done pulse.
REQ-027 computation_done while busy=1 and pend=0: set pend (one-deep) and latch its length_in into pend_len; pend_len is consumed on the next IDLE entry.
REQ-028 computation_done while pend=1 and busy=1: set overrun; the pending request is not replaced.
REQ-029 computation_done in the same cycle that IDLE consumes pend: the new pulse becomes the new pend.
REQ-030 byte_cnt is 10 bits wide and never wraps within a block; N-1 is compared exactly.
REQ-031 out_valid is never asserted outside the EMIT states; rdreq_subblock is never asserted outside READ.

Reset
REQ-032 Asserting reset (low) at any time forces IDLE asynchronously: rdreq_subblock=0, out_valid=0, out_last=0, out_data=0, out_sel=0, busy=0, block_done=0, overrun=0, pend=0, byte_cnt=0, hold registers=0.
REQ-033 Reset mid-block abandons the block; no block_done is issued for it.

Structure
REQ-034 A shared package holds SMALL_BYTES/LARGE_BYTES defaults, the state encoding constants and the stream-select codes.
REQ-035 The design is a single module with no sub-modules; the byte counter is inline.

Verification
REQ-036 Small block, out_ready=1, empty=0: exactly 396 handshakes; out_sel cycles 0,1,2; 132 rdreq pulses; out_last on handshake 396; block_done 1 cycle later.
REQ-037 Large block: exactly 2304 handshakes; out_last only on the final one; busy falls after block_done.
REQ-038 out_ready held low for 7 cycles in EMIT1: out_data and out_sel stay stable; no extra rdreq is issued.
REQ-039 empty=1 for 10 cycles in READ: no rdreq; output resumes correctly once empty=0.
REQ-040 Two computation_done pulses during a block: the second block (with its latched length) starts right after DONE; a third pulse sets overrun=1.
REQ-041 Reset pulse during EMIT2 of byte 50: all outputs zero immediately; no block_done; the next computation_done starts a fresh block at byte 0.
